cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Run/step controller for the single-cycle CPU and DMEM on the FPGA debug top.
- Replaces gated clocks with clock-enable pulses, so the CPU and DMEM run on the free-running board clock.
- Sequences execution from VIO commands: single-step, run for N cycles, free-run, halt, and PC breakpoint.
- Optionally substitutes a VIO-supplied instruction word for IMEM data.

Parameters:
- CW, 32, width of run_count, the internal remaining-cycle counter and the cycles output.
- AW, 32, width of pc and bp_addr.

Ports:
- clk  in  1  board clock; also drives the VIO.
- reset  in  1  asynchronous, active-low; 0 = reset asserted.
- cmd_step  in  1  level from VIO; a rising edge requests one executed cycle.
- cmd_run  in  1  level from VIO; a rising edge starts a run.
- cmd_halt  in  1  level; while 1, execution is forced off.
- run_count  in  CW  cycles per run; 0 = free-run.
- bp_en  in  1  enables the breakpoint compare.
- bp_addr  in  AW  breakpoint PC.
- pc  in  AW  current CPU PC.
- inj_en  in  1  1 = drive inj_data to the CPU instead of IMEM data.
- inj_data  in  32  injected instruction.
- imem_data  in  32  IMEM idata.
- cpu_idata  out  32  instruction to the CPU.
- cpu_ce  out  1  CPU clock enable.
- dmem_ce  out  1  DMEM clock enable.
- state  out  2  FSM state, for VIO readback.
- cycles  out  CW  executed-cycle counter.
- bp_hit  out  1  sticky breakpoint flag.

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE, cpu_ce=0, dmem_ce=0, cycles=0, bp_hit=0.
  - Remaining counter=0, skip=0, edge-detect history=0.
  - A reset mid-run aborts the run immediately; no further enables are issued.
- States: IDLE=0, STEP=1, RUN=2, BRK=3.
- Command edges:
  - step_e and run_e are 1-cycle pulses: input=1 while the registered previous value=0.
  - A level held high produces exactly one pulse.
- Enables:
  - cpu_ce is combinational from registered state: 1 when state=STEP, or when state=RUN and cmd_halt=0 and brk_match=0.
  - brk_match = bp_en & (pc==bp_addr) & ~skip.
  - dmem_ce=cpu_ce in every cycle.
- IDLE and BRK transitions, in priority order:
  - cmd_halt=1: stay.
  - run_e: go to RUN; load remaining=run_count; set skip=1.
  - step_e: go to STEP.
  - run_e and step_e in the same cycle: run wins.
- STEP: executes exactly one enabled cycle, then returns to IDLE unconditionally.
- RUN, evaluated each cycle in priority order:
  - cmd_halt=1: go to IDLE; no enable this cycle.
  - brk_match: go to BRK; no enable. The breakpoint instruction is not executed, and bp_hit is set.
  - Otherwise the cycle is enabled and skip clears.
  - If remaining==1, go to IDLE after this enabled cycle.
  - Otherwise, if remaining!=0, decrement remaining.
  - remaining==0 means free-run until halt or breakpoint.
- Run-length rule: a run with run_count=N>0 and no breakpoint produces exactly N enabled cycles.
- Resume from breakpoint: skip=1 on RUN entry lets the first cycle execute at bp_addr without retriggering. Stepping from BRK also executes the breakpoint instruction.
- bp_hit:
  - Set on entry to BRK.
  - Cleared by run_e or step_e when the command is accepted.
  - A halt does not clear it.
- cycles:
  - Increments by 1 on every cycle with cpu_ce=1.
  - Wraps modulo 2^CW.
  - Cleared only by reset.
- cpu_idata:
  - Combinational: inj_en ? inj_data : imem_data.
  - Independent of state.
- Edge handling: commands arriving while in STEP or RUN are ignored, but their edge history still updates, so no pulse is stored for later.

Decomposition:
- Package cpu_dbg_pkg:
  - State encodings IDLE/STEP/RUN/BRK.
  - Default CW and AW.
  - Typedef for the 2-bit state.
- Sub-module rise_edge: 1-bit registered rising-edge detector with asynchronous active-low reset. Instantiated twice, for step and for run.

Test Plan:
- Reset, then cmd_step 0→1 held for 5 cycles → exactly one cpu_ce/dmem_ce pulse; state IDLE→STEP→IDLE; cycles=1.
- run_count=4, cmd_run rising edge, bp_en=0 → 4 consecutive enables; state returns to IDLE; cycles=4.
- run_count=0, free-run, cmd_halt raised after 10 enables → cpu_ce drops in the same cycle halt is high; state=IDLE; cycles=10.
- bp_en=1, bp_addr=0x10, pc advancing by 4 from 0 under free-run:
  - Enables stop with pc=0x10 held; state=BRK; bp_hit=1.
  - A second run edge → the first cycle is enabled at pc 0x10 and bp_hit clears.
- step and run rising edges in the same cycle with run_count=3 → RUN taken; 3 enables.
- Free-run, reset pulled low mid-run → cpu_ce=0 asynchronously; state=0; cycles=0.
- Injection: inj_en=1, inj_data=0x00100093 → cpu_idata=0x00100093 regardless of imem_data.

Source files
------------

// File: rtl/cpu_dbg_pkg.sv
// Shared encodings and defaults for the debug-top run/step controller.
// State constants are plain 2-bit localparams so VIO readback tooling can decode them directly.
package cpu_dbg_pkg;

  localparam int DEF_CW = 32;
  localparam int DEF_AW = 32;

  typedef logic [1:0] run_state_t;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_STEP = 2'd1;
  localparam logic [1:0] ST_RUN  = 2'd2;
  localparam logic [1:0] ST_BRK  = 2'd3;

endpackage

// File: rtl/cpu_run_ctrl_rise_edge.sv
// Registered rising-edge detector: one-cycle pulse when d goes 0 -> 1.
module rise_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic pulse
);

  logic prev_r;

  // History of the input level from the previous cycle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
    end else begin
      prev_r <= d;
    end
  end

  assign pulse = d & ~prev_r;

endmodule

// File: rtl/cpu_run_ctrl.sv
// Run/step sequencer producing CPU/DMEM clock-enable pulses from VIO commands,
// with run-for-N, free-run, halt, PC breakpoint and instruction injection.
module cpu_run_ctrl
  import cpu_dbg_pkg::*;
#(
  parameter int CW = DEF_CW,
  parameter int AW = DEF_AW
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cmd_step,
  input  logic          cmd_run,
  input  logic          cmd_halt,
  input  logic [CW-1:0] run_count,
  input  logic          bp_en,
  input  logic [AW-1:0] bp_addr,
  input  logic [AW-1:0] pc,
  input  logic          inj_en,
  input  logic [31:0]   inj_data,
  input  logic [31:0]   imem_data,
  output logic [31:0]   cpu_idata,
  output logic          cpu_ce,
  output logic          dmem_ce,
  output logic [1:0]    state,
  output logic [CW-1:0] cycles,
  output logic          bp_hit
);

  run_state_t    state_r, state_nx_s;
  logic [CW-1:0] rem_r, rem_nx_s;
  logic [CW-1:0] cycles_r;
  logic          skip_r, skip_nx_s;
  logic          bp_hit_r, bp_hit_nx_s;
  logic          step_e_s, run_e_s;
  logic          brk_match_s, ce_s;

  rise_edge u_step_edge (.clk(clk), .rst_n(reset), .d(cmd_step), .pulse(step_e_s));
  rise_edge u_run_edge  (.clk(clk), .rst_n(reset), .d(cmd_run),  .pulse(run_e_s));

  // skip suppresses the compare on the first cycle of a run so a resume at bp_addr executes
  assign brk_match_s = bp_en & (pc == bp_addr) & ~skip_r;
  assign ce_s        = (state_r == ST_STEP) |
                       ((state_r == ST_RUN) & ~cmd_halt & ~brk_match_s);

  // Next-state, remaining-count, skip and sticky breakpoint flag
  always_comb begin
    state_nx_s  = state_r;
    rem_nx_s    = rem_r;
    skip_nx_s   = skip_r;
    bp_hit_nx_s = bp_hit_r;
    case (state_r)
      ST_IDLE, ST_BRK: begin
        if (cmd_halt) begin
          state_nx_s = state_r;
        end else if (run_e_s) begin
          state_nx_s  = ST_RUN;
          rem_nx_s    = run_count;
          skip_nx_s   = 1'b1;
          bp_hit_nx_s = 1'b0;
        end else if (step_e_s) begin
          state_nx_s  = ST_STEP;
          bp_hit_nx_s = 1'b0;
        end else begin
          state_nx_s = state_r;
        end
      end
      ST_STEP: begin
        state_nx_s = ST_IDLE;
      end
      ST_RUN: begin
        if (cmd_halt) begin
          state_nx_s = ST_IDLE;
        end else if (brk_match_s) begin
          state_nx_s  = ST_BRK;
          bp_hit_nx_s = 1'b1;
        end else begin
          skip_nx_s = 1'b0;
          // A remaining count of zero means free-run and is never decremented
          if (rem_r == CW'(1)) begin
            state_nx_s = ST_IDLE;
            rem_nx_s   = {CW{1'b0}};
          end else if (rem_r != {CW{1'b0}}) begin
            rem_nx_s = rem_r - CW'(1);
          end else begin
            rem_nx_s = rem_r;
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
      end
    endcase
  end

  // Controller state registers and executed-cycle counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r  <= ST_IDLE;
      rem_r    <= {CW{1'b0}};
      skip_r   <= 1'b0;
      bp_hit_r <= 1'b0;
      cycles_r <= {CW{1'b0}};
    end else begin
      state_r  <= state_nx_s;
      rem_r    <= rem_nx_s;
      skip_r   <= skip_nx_s;
      bp_hit_r <= bp_hit_nx_s;
      if (ce_s) begin
        cycles_r <= cycles_r + CW'(1);
      end else begin
        cycles_r <= cycles_r;
      end
    end
  end

  assign cpu_ce    = ce_s;
  assign dmem_ce   = ce_s;
  assign state     = state_r;
  assign cycles    = cycles_r;
  assign bp_hit    = bp_hit_r;
  assign cpu_idata = inj_en ? inj_data : imem_data;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Table-driven bench for cpu_run_ctrl: per-cycle vectors through a scoreboard queue,
// plus hand sequences for asynchronous reset mid-run and instruction injection.
module tb_cpu_run_ctrl;
  import cpu_dbg_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_step, cmd_run, cmd_halt;
  logic [31:0] run_count;
  logic        bp_en;
  logic [31:0] bp_addr, pc;
  logic        inj_en;
  logic [31:0] inj_data, imem_data;
  logic [31:0] cpu_idata;
  logic        cpu_ce, dmem_ce;
  logic [1:0]  state;
  logic [31:0] cycles;
  logic        bp_hit;

  always #5 clk = ~clk;

  cpu_run_ctrl #(.CW(32), .AW(32)) dut (
    .clk(clk), .reset(reset), .cmd_step(cmd_step), .cmd_run(cmd_run),
    .cmd_halt(cmd_halt), .run_count(run_count), .bp_en(bp_en), .bp_addr(bp_addr),
    .pc(pc), .inj_en(inj_en), .inj_data(inj_data), .imem_data(imem_data),
    .cpu_idata(cpu_idata), .cpu_ce(cpu_ce), .dmem_ce(dmem_ce), .state(state),
    .cycles(cycles), .bp_hit(bp_hit)
  );

  typedef struct {
    logic        step, run, halt;
    logic [31:0] rc;
    logic        bp;
    logic [31:0] pcv;
    logic        ce;
    logic [1:0]  st;
    logic [31:0] cyc;
    logic        hit;
  } vec_t;

  vec_t        vecs[$];
  vec_t        sb[$];
  logic [31:0] exp_q[$];
  int          n_vec = 0;
  int          n_bad = 0;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  task automatic add(input logic s, input logic r, input logic h, input logic [31:0] rc,
                     input logic b, input logic [31:0] p, input logic ce,
                     input logic [1:0] st, input logic [31:0] cyc, input logic hit);
    vec_t v;
    v.step = s; v.run = r; v.halt = h; v.rc = rc; v.bp = b; v.pcv = p;
    v.ce = ce; v.st = st; v.cyc = cyc; v.hit = hit;
    vecs.push_back(v);
  endtask

  initial begin
    vec_t e;
    logic [31:0] ev;

    // Step held high for several cycles: one pulse only
    add(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd0, 1'b0);
    add(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1, ST_STEP, 32'd0, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd1, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd1, 1'b0);
    // Run for 4 cycles
    add(1'b0, 1'b1, 1'b0, 32'd4, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd1, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 32'd4, 1'b0, 32'h0, 1'b1, ST_RUN, 32'd1 + 32'(k), 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd4, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd5, 1'b0);
    // Free-run, halted after 10 enables
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd5, 1'b0);
    for (int k = 0; k < 10; k++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b1, ST_RUN, 32'd5 + 32'(k), 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'h0, 1'b0, ST_RUN,  32'd15, 1'b0);
    add(1'b0, 1'b0, 1'b1, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    // Run edge during halt is lost, and the held level does not re-trigger
    add(1'b0, 1'b1, 1'b1, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    // Step and run edges together: run wins, 3 enables
    add(1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd15, 1'b0);
    for (int k = 0; k < 3; k++) add(1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 32'h0, 1'b1, ST_RUN, 32'd15 + 32'(k), 1'b0);
    add(1'b1, 1'b1, 1'b0, 32'd3, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd18, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd3, 1'b0, 32'h0, 1'b0, ST_IDLE, 32'd18, 1'b0);
    // Breakpoint at 0x10 with pc advancing by 4
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h0, 1'b0, ST_IDLE, 32'd18, 1'b0);
    for (int k = 0; k < 4; k++) add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'(4 * k), 1'b1, ST_RUN, 32'd18 + 32'(k), 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_RUN, 32'd22, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd22, 1'b1);
    add(1'b0, 1'b0, 1'b1, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd22, 1'b1);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd22, 1'b1);
    // Resume: first cycle at bp_addr executes, flag clears
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd22, 1'b1);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, ST_RUN, 32'd22, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h14, 1'b1, ST_RUN, 32'd23, 1'b0);
    add(1'b0, 1'b1, 1'b1, 32'd0, 1'b1, 32'h18, 1'b0, ST_RUN, 32'd24, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h18, 1'b0, ST_IDLE, 32'd24, 1'b0);
    // Re-hit the breakpoint on the second cycle, then step out of BRK
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_IDLE, 32'd24, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, ST_RUN, 32'd24, 1'b0);
    add(1'b0, 1'b1, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_RUN, 32'd25, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd25, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b0, ST_BRK, 32'd25, 1'b1);
    add(1'b1, 1'b0, 1'b0, 32'd0, 1'b1, 32'h10, 1'b1, ST_STEP, 32'd25, 1'b0);
    add(1'b0, 1'b0, 1'b0, 32'd0, 1'b1, 32'h14, 1'b0, ST_IDLE, 32'd26, 1'b0);

    reset = 1'b0; cmd_step = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b0;
    run_count = 32'd0; bp_en = 1'b0; bp_addr = 32'h10; pc = 32'h0;
    inj_en = 1'b0; inj_data = 32'h0; imem_data = 32'h0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset ce", {31'd0, cpu_ce}, 32'd0);
    check("reset state", {30'd0, state}, {30'd0, ST_IDLE});
    check("reset cycles", cycles, 32'd0);
    check("reset bp_hit", {31'd0, bp_hit}, 32'd0);
    reset = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      @(posedge clk); #1;
      cmd_step = vecs[i].step; cmd_run = vecs[i].run; cmd_halt = vecs[i].halt;
      run_count = vecs[i].rc; bp_en = vecs[i].bp; pc = vecs[i].pcv;
      sb.push_back(vecs[i]);
      @(negedge clk);
      e = sb.pop_front();
      check($sformatf("v%0d cpu_ce", i), {31'd0, cpu_ce}, {31'd0, e.ce});
      check($sformatf("v%0d dmem_ce", i), {31'd0, dmem_ce}, {31'd0, e.ce});
      check($sformatf("v%0d state", i), {30'd0, state}, {30'd0, e.st});
      check($sformatf("v%0d cycles", i), cycles, e.cyc);
      check($sformatf("v%0d bp_hit", i), {31'd0, bp_hit}, {31'd0, e.hit});
    end

    // Free-run, then asynchronous reset in the middle of a cycle
    @(posedge clk); #1;
    cmd_step = 1'b0; cmd_run = 1'b0; cmd_halt = 1'b0; bp_en = 1'b0; run_count = 32'd0;
    @(posedge clk); #1; cmd_run = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    exp_q.push_back(32'd1);
    check("midrun ce before reset", {31'd0, cpu_ce}, exp_q.pop_front());
    #2; reset = 1'b0; #1;
    exp_q.push_back(32'd0); exp_q.push_back({30'd0, ST_IDLE}); exp_q.push_back(32'd0);
    check("async reset ce", {31'd0, cpu_ce}, exp_q.pop_front());
    check("async reset state", {30'd0, state}, exp_q.pop_front());
    check("async reset cycles", cycles, exp_q.pop_front());
    cmd_run = 1'b0;
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    check("reset hold ce", {31'd0, dmem_ce}, exp_q.pop_front());
    @(negedge clk); reset = 1'b1;
    @(posedge clk); #1;
    exp_q.push_back(32'd0);
    check("post reset cycles", cycles, exp_q.pop_front());

    // Instruction injection is a pure mux, independent of state
    for (int k = 0; k < 4; k++) begin
      inj_en = 1'b1; inj_data = 32'h0010_0093; imem_data = $urandom;
      exp_q.push_back(32'h0010_0093);
      #1;
      check($sformatf("inj%0d idata", k), cpu_idata, exp_q.pop_front());
      inj_en = 1'b0; imem_data = $urandom;
      exp_q.push_back(imem_data);
      #1;
      check($sformatf("imem%0d idata", k), cpu_idata, exp_q.pop_front());
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
